// File: rtl/gpio_arb_defines.sv
// Shared encodings for the GPIO Wishbone arbiter.
package gpio_arb_defines;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ABORT = 2'd2
  } arb_state_t;

  localparam int TCNT_W = 8;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin pick: first set request at or after ptr, wrapping, as a one-hot vector.
module rr_priority_picker #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;
  logic [2*N-1:0] first;

  // Bits below ptr are masked in the low copy; the high copy supplies the wrap-around.
  always_comb begin
    dbl    = {req, req};
    masked = dbl & ({(2*N){1'b1}} << ptr);
    first  = masked & (~masked + {{(2*N-1){1'b0}}, 1'b1});
    pick   = first[N-1:0] | first[2*N-1:N];
  end

endmodule

// File: rtl/gpio_wb_arbiter.sv
// Round-robin Wishbone classic arbiter sharing the GPIO slave between several masters,
// with a stall timeout that terminates the cycle with a bus error.
module gpio_wb_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = 3,
  parameter int DW          = 8,
  parameter int TIMEOUT     = 255
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic [NUM_MASTERS-1:0]    m_cyc_i,
  input  logic [NUM_MASTERS-1:0]    m_stb_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [NUM_MASTERS*AW-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0] m_dat_i,
  output logic [DW-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]    m_ack_o,
  output logic [NUM_MASTERS-1:0]    m_err_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic                      s_we_o,
  output logic [AW-1:0]             s_adr_o,
  output logic [DW-1:0]             s_dat_o,
  input  logic [DW-1:0]             s_dat_i,
  input  logic                      s_ack_i,
  output logic [NUM_MASTERS-1:0]    grant_o
);
  import gpio_arb_defines::*;

  // state    | meaning
  // ST_IDLE  | no owner; pick a requester next edge
  // ST_GRANT | granted master drives the slave until it drops CYC
  // ST_ABORT | timed out; slave isolated until owner drops CYC

  localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [TCNT_W-1:0] TO_VAL = TCNT_W'(TIMEOUT);

  arb_state_t              state_q, state_d;
  logic [NUM_MASTERS-1:0]  grant_q, grant_d;
  logic [PW-1:0]           gidx_q, gidx_d;
  logic [PW-1:0]           ptr_q, ptr_d;
  logic [TCNT_W-1:0]       tcnt_q, tcnt_d;

  logic [NUM_MASTERS-1:0]  pick;
  logic [PW-1:0]           pick_idx;
  logic [PW-1:0]           ptr_next;
  logic                    in_grant;
  logic                    cyc_g, stb_g, we_g;
  logic [AW-1:0]           adr_g;
  logic [DW-1:0]           dat_g;
  logic                    timeout_hit;

  rr_priority_picker #(
    .N  (NUM_MASTERS),
    .PW (PW)
  ) u_picker (
    .req  (m_cyc_i),
    .ptr  (ptr_q),
    .pick (pick)
  );

  always_comb begin
    pick_idx = '0;
    adr_g    = '0;
    dat_g    = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (pick[k]) pick_idx = PW'(k);
      if (grant_q[k]) begin
        adr_g = adr_g | m_adr_i[k*AW +: AW];
        dat_g = dat_g | m_dat_i[k*DW +: DW];
      end
    end
  end

  assign cyc_g    = |(m_cyc_i & grant_q);
  assign stb_g    = |(m_stb_i & m_cyc_i & grant_q);
  assign we_g     = |(m_we_i & grant_q);
  assign in_grant = (state_q == ST_GRANT);
  assign ptr_next = (gidx_q == PW'(NUM_MASTERS - 1)) ? '0 : gidx_q + PW'(1);

  // An ACK on the threshold cycle still completes the beat normally.
  assign timeout_hit = in_grant && stb_g && !s_ack_i && (tcnt_q == TO_VAL);

  assign s_cyc_o = in_grant && cyc_g && !timeout_hit;
  assign s_stb_o = in_grant && stb_g && !timeout_hit;
  assign s_we_o  = in_grant && we_g;
  assign s_adr_o = in_grant ? adr_g : '0;
  assign s_dat_o = in_grant ? dat_g : '0;
  assign m_ack_o = in_grant ? (grant_q & {NUM_MASTERS{s_ack_i}}) : '0;
  assign m_err_o = timeout_hit ? grant_q : '0;
  assign m_dat_o = s_dat_i;
  assign grant_o = grant_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    tcnt_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (|m_cyc_i) begin
          grant_d = pick;
          gidx_d  = pick_idx;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!cyc_g) begin
          state_d = ST_IDLE;
          grant_d = '0;
          ptr_d   = ptr_next;
        end else if (timeout_hit) begin
          state_d = ST_ABORT;
        end else if (stb_g && !s_ack_i) begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end
      ST_ABORT: begin
        if (!cyc_g) begin
          state_d = ST_IDLE;
          grant_d = '0;
          ptr_d   = ptr_next;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      tcnt_q  <= tcnt_d;
    end
  end

endmodule

// File: doc/gpio_wb_arbiter.md
Name: gpio_wb_arbiter

Overview:
- Round-robin Wishbone B3 classic arbiter that shares the single 8-bit GPIO slave (gpio0) among NUM_MASTERS requesters (e.g. CPU data bus, debug unit, test sequencer).
- Sits between the masters and the GPIO slave inside orpsoc_top, on the wb_clk_i domain.
- Holds a grant for a whole bus cycle (CYC), rotates priority fairly, and aborts stalled cycles with a bus error after a timeout.

Parameters:
- NUM_MASTERS, 2: number of requesting masters (2..4).
- AW, 3: GPIO slave address width.
- DW, 8: data width.
- TIMEOUT, 255: cycles with STB high and no ACK before abort (1..255; counter is 8 bits).

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  reset; synchronous, active-high.
- m_cyc_i  in  NUM_MASTERS  per-master CYC.
- m_stb_i  in  NUM_MASTERS  per-master STB.
- m_we_i  in  NUM_MASTERS  per-master WE.
- m_adr_i  in  NUM_MASTERS*AW  packed addresses; master k at [k*AW +: AW].
- m_dat_i  in  NUM_MASTERS*DW  packed write data.
- m_dat_o  out  DW  read data, broadcast to all masters.
- m_ack_o  out  NUM_MASTERS  per-master ACK.
- m_err_o  out  NUM_MASTERS  per-master ERR.
- s_cyc_o  out  1  slave CYC.
- s_stb_o  out  1  slave STB.
- s_we_o  out  1  slave WE.
- s_adr_o  out  AW  slave address.
- s_dat_o  out  DW  slave write data.
- s_dat_i  in  DW  slave read data.
- s_ack_i  in  1  slave ACK.
- grant_o  out  NUM_MASTERS  one-hot registered grant (debug/visibility).

Behaviour:
- Reset (wb_rst_i high at a clock edge):
  - grant_o = 0, state = IDLE, rr pointer = 0 (master 0 has highest priority first), timeout counter = 0.
  - All s_* outputs and m_ack_o/m_err_o are 0 from the first edge with reset high, including when reset arrives mid-transfer.
- State machine:
  - IDLE:
    - If any m_cyc_i is set, pick the first requester at or after the pointer, wrapping modulo NUM_MASTERS. Register its one-hot grant, go to GRANT.
    - Arbitration latency is one cycle: s_cyc_o asserts the cycle after m_cyc_i is first seen.
  - GRANT:
    - s_cyc_o/s_stb_o/s_we_o/s_adr_o/s_dat_o are driven combinationally from the granted master's inputs, gated by the grant.
    - m_ack_o[g] = s_ack_i only for the granted master g; all other acks/errs are 0.
    - m_dat_o = s_dat_i at all times.
    - Grant is held across multiple STB beats while m_cyc_i[g] stays high.
    - When m_cyc_i[g] falls: go to IDLE, pointer = (g+1) mod NUM_MASTERS, grant_o cleared.
    - Other masters' requests are ignored until IDLE is re-entered.
  - Timeout:
    - In GRANT, the counter increments each cycle with s_stb_o=1 and s_ack_i=0. It clears on ACK or when STB is low.
    - When the counter reaches TIMEOUT (with no ACK that cycle): pulse m_err_o[g] for exactly one cycle, force s_cyc_o/s_stb_o to 0, go to ABORT.
  - ABORT:
    - Slave outputs stay 0; a late s_ack_i is ignored and not forwarded.
    - Wait for m_cyc_i[g]=0, then go to IDLE and advance the pointer as above.
- Boundary cases:
  - ACK and timeout-threshold in the same cycle: ACK wins, counter clears, no ERR.
  - CYC drop and another master's request in the same cycle: one IDLE cycle occurs, then grant; there is always a minimum one-cycle gap between grants.
  - Single requester re-requesting immediately: it is re-granted after the IDLE gap, since the pointer wraps back to it.
  - m_stb_i without m_cyc_i is ignored.
  - Unused grant bits never assert.
  - grant_o is always one-hot or zero.

Decomposition:
- Shared package/include gpio_arb_defines: state encodings (IDLE=2'd0, GRANT=2'd1, ABORT=2'd2) and the timeout counter width constant (8).
- Sub-module rr_priority_picker: combinational. Inputs are the request vector and pointer; output is a one-hot pick, produced by a double-width mask-and-find-first.
- The arbiter FSM, counter and mux stay in gpio_wb_arbiter.

Test Plan:
- Reset then m0 write 0xA5 to adr 1:
  - s_cyc_o rises 1 cycle after m_cyc_i[0].
  - Slave sees adr 1, dat 0xA5; m_ack_o=2'b01; grant_o returns to 0 after CYC drop.
- m0 and m1 request in the same cycle from reset:
  - m0 is granted first.
  - After m0 drops CYC, m1 is granted after one IDLE cycle.
  - The next simultaneous request grants m1's successor (m0 again, since the pointer advanced to 0 after m1).
- m0 holds CYC for a 3-beat burst while m1 requests:
  - All 3 acks go to m0 only; m1 is granted only after m0 drops CYC.
- Slave never acks with TIMEOUT=4:
  - m_err_o[0] pulses exactly once, 4 cycles after STB.
  - s_cyc_o drops the same cycle; a late s_ack_i is not forwarded.
  - After m0 drops CYC, m1 can be granted.
- wb_rst_i asserted mid-transfer with m1 granted:
  - The next edge clears grant_o and s_cyc_o.
  - After reset release, the pointer is 0, so simultaneous requests grant m0.
